// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: copies XFER_LEN bytes from {src_hi, idx} to OAM_BASE+idx,
// one byte per M-cycle, and fences CPU accesses off the bus while it owns it.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int          XFER_LEN     = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  t_cycle,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_data,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_wdata,
  output logic        dma_rd,
  output logic        dma_wr,
  output logic        mem_ctrl_sel,
  output logic        cpu_blocked,
  output logic [7:0]  reg_rdata,
  output logic        dma_active
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } state_t;

  localparam logic [7:0] IDX_LAST = 8'(XFER_LEN - 1);

  state_t      state_q, state_d;
  logic [7:0]  idx_q;
  logic [7:0]  src_hi_q;
  logic [7:0]  eff_hi;
  logic        trigger;
  logic        hram_hit;

  // Echo RAM (E000..FDFF) mirrors work RAM at C000..DDFF.
  assign eff_hi   = (src_hi_q >= 8'hE0) ? (src_hi_q - 8'h20) : src_hi_q;
  assign trigger  = cpu_wr && (cpu_addr == DMA_REG_ADDR) && (t_cycle == 2'd3);
  assign hram_hit = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);

  // NOTE: every output of this block gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    dma_addr     = 16'h0000;
    dma_rd       = 1'b0;
    dma_wr       = 1'b0;
    mem_ctrl_sel = 1'b0;
    dma_active   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trigger) state_d = START;
      end
      START: begin
        dma_active = 1'b1;
        if (trigger)                state_d = START;
        else if (t_cycle == 2'd3)   state_d = XFER;
      end
      XFER: begin
        dma_active   = 1'b1;
        mem_ctrl_sel = 1'b1;
        // T0-T1 read the source byte, T2-T3 write it into OAM.
        if (!t_cycle[1]) begin
          dma_rd   = 1'b1;
          dma_addr = {eff_hi, idx_q};
        end else begin
          dma_wr   = 1'b1;
          dma_addr = OAM_BASE + {8'h00, idx_q};
        end
        if (trigger)                                    state_d = START;
        else if ((t_cycle == 2'd3) && (idx_q == IDX_LAST)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // High RAM and the DMA register itself stay reachable during a transfer.
  assign cpu_blocked = mem_ctrl_sel && (cpu_rd || cpu_wr) && !hram_hit &&
                       (cpu_addr != DMA_REG_ADDR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 8'h00;
      src_hi_q  <= 8'h00;
      reg_rdata <= 8'h00;
      dma_wdata <= 8'h00;
    end else begin
      state_q <= state_d;
      if (trigger) begin
        src_hi_q  <= cpu_data;
        reg_rdata <= cpu_data;
      end
      if ((state_q == XFER) && (t_cycle == 2'd1)) dma_wdata <= mem_rdata;
      if ((state_q == START) && (state_d == XFER)) idx_q <= 8'h00;
      else if ((state_q == XFER) && (t_cycle == 2'd3)) idx_q <= idx_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: scoreboard of expected byte moves,
// table-driven CPU fencing vectors, and restart/reset corner sequences.
module tb_oam_dma_ctrl;

  localparam logic [15:0] DMA_REG = 16'hFF46;
  localparam logic [15:0] OAM     = 16'hFE00;
  localparam int          LEN     = 160;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  t_cycle;
  logic [15:0] cpu_addr;
  logic        cpu_wr, cpu_rd;
  logic [7:0]  cpu_data, mem_rdata;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata, reg_rdata;
  logic        dma_rd, dma_wr, mem_ctrl_sel, cpu_blocked, dma_active;

  oam_dma_ctrl #(.DMA_REG_ADDR(DMA_REG), .OAM_BASE(OAM), .XFER_LEN(LEN)) dut (
    .clk(clk), .rst(rst), .t_cycle(t_cycle), .cpu_addr(cpu_addr),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_data(cpu_data), .mem_rdata(mem_rdata),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rd(dma_rd), .dma_wr(dma_wr),
    .mem_ctrl_sel(mem_ctrl_sel), .cpu_blocked(cpu_blocked),
    .reg_rdata(reg_rdata), .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [7:0]  data;
  } xfer_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic        exp_blk;
  } vec_t;

  xfer_t sb[$];
  vec_t  vecs[10];
  int    n_cmp  = 0;
  int    n_fail = 0;
  int    n_wr   = 0;
  logic  mon_en = 1'b0;

  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1 t_cycle = t_cycle + 2'd1;
    #1 mem_rdata = mem_fn(dma_addr);
  endtask

  task automatic trigger(input logic [7:0] v);
    int guard = 0;
    logic [7:0] hi;
    while (t_cycle != 2'd3 && guard < 8) begin tick(); guard++; end
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = DMA_REG; cpu_data = v;
    hi = (v >= 8'hE0) ? v - 8'h20 : v;
    sb.delete();
    for (int i = 0; i < LEN; i++) begin
      xfer_t x;
      x.src  = {hi, 8'(i)};
      x.dst  = OAM + 16'(i);
      x.data = mem_fn(x.src);
      sb.push_back(x);
    end
    tick();
    cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_data = 8'h00;
    check("reg_rdata_after_trigger", reg_rdata, v);
    check("start_active", dma_active, 1);
    check("start_sel_low", mem_ctrl_sel, 0);
  endtask

  task automatic wait_idle(output int n, output int first_rd);
    n = 0; first_rd = -1;
    while (dma_active && n < 2000) begin
      if (dma_rd && first_rd < 0) first_rd = n;
      tick(); n++;
    end
  endtask

  // Bus monitor: invariants every cycle, scoreboard on each read/write beat.
  always @(negedge clk) begin
    if (mon_en) begin
      check("rd_wr_exclusive", dma_rd & dma_wr, 0);
      check("sel_matches_strobes", mem_ctrl_sel, dma_rd | dma_wr);
      check("sel_implies_active", mem_ctrl_sel & ~dma_active, 0);
      if (dma_rd && t_cycle == 2'd0) begin
        if (sb.size() == 0) check("unexpected_read", dma_addr, 32'hDEAD);
        else                check("read_addr", dma_addr, sb[0].src);
      end
      if (dma_wr && t_cycle == 2'd2) begin
        n_wr++;
        if (sb.size() == 0) check("unexpected_write", dma_addr, 32'hDEAD);
        else begin
          check("write_addr", dma_addr, sb[0].dst);
          check("write_data", dma_wdata, sb[0].data);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first_rd, guard;

    vecs[0] = '{1'b1, 1'b0, 16'hC000, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 16'hFF90, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 16'hFF46, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 16'hFF80, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'hFFFE, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 16'hFFFF, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 16'hFF7F, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 16'h8000, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 16'hC000, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 16'hFF46, 1'b0};

    t_cycle = 2'd0; rst = 1'b1; cpu_addr = 16'hC000; cpu_wr = 1'b0; cpu_rd = 1'b1;
    cpu_data = 8'h00; mem_rdata = 8'h00;
    repeat (3) tick();
    check("rst_dma_addr", dma_addr, 0);
    check("rst_dma_wdata", dma_wdata, 0);
    check("rst_dma_rd", dma_rd, 0);
    check("rst_dma_wr", dma_wr, 0);
    check("rst_sel", mem_ctrl_sel, 0);
    check("rst_blocked", cpu_blocked, 0);
    check("rst_reg_rdata", reg_rdata, 0);
    check("rst_active", dma_active, 0);
    rst = 1'b0; cpu_rd = 1'b0; cpu_addr = 16'h0000;
    tick();
    mon_en = 1'b1;

    // Full transfer from C100: 4 START clocks, 644 clocks total.
    n_wr = 0;
    trigger(8'hC1);
    wait_idle(n, first_rd);
    check("c1_total_clocks", n, 644);
    check("c1_first_read_clock", first_rd, 4);
    check("c1_write_count", n_wr, LEN);
    check("c1_sb_empty", sb.size(), 0);

    // Echo-RAM source, CPU fencing vectors, then random CPU traffic.
    n_wr = 0;
    trigger(8'hE3);
    repeat (8) tick();
    for (int i = 0; i < 10; i++) begin
      if (t_cycle == 2'd3) tick();
      cpu_rd = vecs[i].rd; cpu_wr = vecs[i].wr; cpu_addr = vecs[i].addr;
      #1 check($sformatf("cpu_blocked_vec%0d", i), cpu_blocked, vecs[i].exp_blk);
      check("reg_readback_in_xfer", reg_rdata, 8'hE3);
      tick();
      cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000;
    end
    guard = 0;
    while (dma_active && guard < 2000) begin
      cpu_rd   = 1'($urandom_range(0, 1));
      cpu_wr   = 1'($urandom_range(0, 1));
      cpu_addr = 16'($urandom);
      if (cpu_addr == DMA_REG) cpu_addr = 16'hFF47;
      tick(); guard++;
    end
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000;
    check("e3_finished", dma_active, 0);
    check("e3_write_count", n_wr, LEN);

    // Restart at idx 50: byte 50 completes, then a fresh transfer from D000.
    n_wr = 0;
    trigger(8'hC1);
    guard = 0;
    while (!(n_wr == 51 && t_cycle == 2'd3) && guard < 1000) begin tick(); guard++; end
    check("restart_reached_idx50", n_wr, 51);
    trigger(8'hD0);
    wait_idle(n, first_rd);
    check("d0_total_clocks", n, 644);
    check("d0_first_read_clock", first_rd, 4);
    check("restart_write_count", n_wr, LEN + 51);

    // Reset mid-transfer at idx 10, then a clean transfer from 8000.
    n_wr = 0;
    trigger(8'hC1);
    guard = 0;
    while (!(n_wr == 10 && t_cycle == 2'd0) && guard < 1000) begin tick(); guard++; end
    check("reset_reached_idx10", n_wr, 10);
    rst = 1'b1; cpu_rd = 1'b1; cpu_addr = 16'hC000;
    tick();
    sb.delete();
    check("abort_dma_addr", dma_addr, 0);
    check("abort_dma_wdata", dma_wdata, 0);
    check("abort_dma_rd", dma_rd, 0);
    check("abort_dma_wr", dma_wr, 0);
    check("abort_sel", mem_ctrl_sel, 0);
    check("abort_blocked", cpu_blocked, 0);
    check("abort_reg_rdata", reg_rdata, 0);
    check("abort_active", dma_active, 0);
    rst = 1'b0;
    tick();
    check("post_reset_idle", dma_active, 0);
    repeat (40) tick();
    check("no_writes_after_abort", n_wr, 10);
    cpu_rd = 1'b0; cpu_addr = 16'h0000;
    n_wr = 0;
    trigger(8'h80);
    wait_idle(n, first_rd);
    check("x80_total_clocks", n, 644);
    check("x80_first_read_clock", first_rd, 4);
    check("x80_write_count", n_wr, LEN);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
